// File: rtl/ifm_buf_loader.sv
// Purpose : packs a 32-bit IFM beat stream into 128-bit buffer words and writes them tile by tile,
//           issuing buffer-switch / loop-end pulses and tracking filled ping-pong halves.
// Latency : word write one cycle after its 4th beat; switch pulse one cycle after the tile's last write.
// Backpressure: in_ready only in LOAD; LOAD is entered only while fewer than two halves are unreleased.
//
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_start, i_cfg_tile_len/num    loop start pulse and its configuration (0 encodes the maximum)
//   i_in_data/i_in_valid/o_in_ready  input beat stream
//   i_buf_rd_done                  consumer released one full buffer
//   o_ifm_wr_en/addr, o_ifm_in     buffer word write port
//   o_buf_in_switch, o_loop_end    tile-end / loop-end pulses
//   o_busy                         loop in progress
module ifm_buf_loader #(
    parameter int IN_W   = 32,
    parameter int ADDR_W = 10
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_cfg_tile_len,
    input  logic [7:0]          i_cfg_tile_num,
    input  logic [IN_W-1:0]     i_in_data,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic                i_buf_rd_done,
    output logic                o_ifm_wr_en,
    output logic [ADDR_W-1:0]   o_ifm_wr_addr,
    output logic [4*IN_W-1:0]   o_ifm_in,
    output logic                o_buf_in_switch,
    output logic                o_loop_end,
    output logic                o_busy
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_BUF = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_SWITCH   = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]        TILE_ONE = 8'd1;

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_tile_len;
    logic [7:0]          r_tile_num;
    logic [1:0]          r_beat_cnt;
    logic [ADDR_W-1:0]   r_word_cnt;
    logic [7:0]          r_tile_cnt;
    logic [1:0]          r_full_cnt;
    logic [3*IN_W-1:0]   r_pack;

    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [4*IN_W-1:0]   r_ifm_in;
    logic                r_buf_in_switch;
    logic                r_loop_end;
    logic                r_busy;

    logic                w_accept;
    logic                w_word_last;
    logic                w_tile_last;
    logic                w_full_inc;
    logic                w_full_dec;

    // A configured length of 0 encodes the maximum; subtracting one in the
    // native width wraps 0 to all-ones, so both encodings share one compare.
    assign w_accept    = i_in_valid && (r_state == S_LOAD);
    assign w_word_last = (r_word_cnt == (r_tile_len - ADDR_ONE));
    assign w_tile_last = (r_tile_cnt == (r_tile_num - TILE_ONE));

    // full_cnt moves on the same edge that raises buf_in_switch, so WAIT_BUF
    // already sees the new fill level in the cycle the pulse is visible.
    assign w_full_inc  = (r_state == S_SWITCH);
    assign w_full_dec  = i_buf_rd_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_tile_len      <= '0;
            r_tile_num      <= '0;
            r_beat_cnt      <= '0;
            r_word_cnt      <= '0;
            r_tile_cnt      <= '0;
            r_pack          <= '0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= '0;
            r_ifm_in        <= '0;
            r_buf_in_switch <= 1'b0;
            r_loop_end      <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_wr_en         <= 1'b0;
            r_buf_in_switch <= 1'b0;
            r_loop_end      <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_tile_len <= i_cfg_tile_len;
                        r_tile_num <= i_cfg_tile_num;
                        r_beat_cnt <= '0;
                        r_word_cnt <= '0;
                        r_tile_cnt <= '0;
                        r_pack     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_WAIT_BUF;
                    end
                end

                S_WAIT_BUF: begin
                    if (r_full_cnt < 2'd2) begin
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        if (r_beat_cnt == 2'd3) begin
                            // Last beat goes straight to the MSBs; earlier beats come from the pack.
                            r_wr_en    <= 1'b1;
                            r_ifm_in   <= {i_in_data, r_pack};
                            r_wr_addr  <= r_word_cnt;
                            r_beat_cnt <= '0;
                            r_word_cnt <= r_word_cnt + ADDR_ONE;
                            if (w_word_last) begin
                                r_state <= S_SWITCH;
                            end
                        end else begin
                            case (r_beat_cnt)
                                2'd0:    r_pack[0*IN_W +: IN_W] <= i_in_data;
                                2'd1:    r_pack[1*IN_W +: IN_W] <= i_in_data;
                                default: r_pack[2*IN_W +: IN_W] <= i_in_data;
                            endcase
                            r_beat_cnt <= r_beat_cnt + 2'd1;
                        end
                    end
                end

                S_SWITCH: begin
                    // The final tile raises both pulses so the fill count stays uniform;
                    // the downstream selector resolves loop_end first.
                    r_buf_in_switch <= 1'b1;
                    r_word_cnt      <= '0;
                    if (w_tile_last) begin
                        r_loop_end <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_tile_cnt <= r_tile_cnt + TILE_ONE;
                        r_state    <= S_WAIT_BUF;
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Filled-half counter: a release with nothing filled is dropped, and a
    // fill coinciding with a release leaves the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full_cnt <= '0;
        end else begin
            if (w_full_inc && !w_full_dec) begin
                if (r_full_cnt != 2'd2) begin
                    r_full_cnt <= r_full_cnt + 2'd1;
                end
            end else if (w_full_dec && !w_full_inc) begin
                if (r_full_cnt != 2'd0) begin
                    r_full_cnt <= r_full_cnt - 2'd1;
                end
            end
        end
    end

    assign o_in_ready      = (r_state == S_LOAD);
    assign o_ifm_wr_en     = r_wr_en;
    assign o_ifm_wr_addr   = r_wr_addr;
    assign o_ifm_in        = r_ifm_in;
    assign o_buf_in_switch = r_buf_in_switch;
    assign o_loop_end      = r_loop_end;
    assign o_busy          = r_busy;

endmodule

// File: tb/tb_ifm_buf_loader.sv
// Purpose : randomized scoreboard bench for ifm_buf_loader against a word/tile-level reference model.
// Latency : expectations are queued at loop start; a negedge monitor pops them as the DUT writes/pulses.
// Backpressure: stimulus drives in_valid in continuous, alternating or random patterns; a consumer model releases buffers.
module tb_ifm_buf_loader;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [9:0]    cfg_tile_len;
    logic [7:0]    cfg_tile_num;
    logic [31:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic          buf_rd_done;
    logic          ifm_wr_en;
    logic [9:0]    ifm_wr_addr;
    logic [127:0]  ifm_in;
    logic          buf_in_switch;
    logic          loop_end;
    logic          busy;

    logic          rel_auto = 1'b0;
    logic          rel_man  = 1'b0;
    assign buf_rd_done = rel_auto | rel_man;

    always #5 clk = ~clk;

    ifm_buf_loader #(.IN_W(32), .ADDR_W(10)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_cfg_tile_len  (cfg_tile_len),
        .i_cfg_tile_num  (cfg_tile_num),
        .i_in_data       (in_data),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_buf_rd_done   (buf_rd_done),
        .o_ifm_wr_en     (ifm_wr_en),
        .o_ifm_wr_addr   (ifm_wr_addr),
        .o_ifm_in        (ifm_in),
        .o_buf_in_switch (buf_in_switch),
        .o_loop_end      (loop_end),
        .o_busy          (busy)
    );

    typedef struct {
        logic [9:0]   addr;
        logic [127:0] data;
    } wr_t;

    int          n_cmp = 0;
    int          n_err = 0;
    wr_t         exp_wr[$];
    bit          exp_sw[$];
    logic [31:0] beats[$];
    int          sw_seen    = 0;
    int          rel_issued = 0;
    bit          auto_rel   = 1'b0;
    bit          sync_req   = 1'b0;
    longint      cyc        = 0;
    longint      last_wr    = -100;
    bit          le_prev    = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not expected / bound expired", name);
    endtask

    // Monitor: every DUT write or pulse is matched against the queued expectation.
    always @(negedge clk) begin
        wr_t e;
        bit  le;
        cyc++;
        if (rst_n) begin
            if (ifm_wr_en) begin
                if (exp_wr.size() == 0) begin
                    fail_now("unexpected_wr");
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", {118'd0, ifm_wr_addr}, {118'd0, e.addr});
                    check("wr_data", ifm_in, e.data);
                end
                last_wr = cyc;
            end
            if (le_prev) check("busy_after_loop_end", {127'd0, busy}, 128'd0);
            le_prev = loop_end;
            if (buf_in_switch) begin
                sw_seen++;
                check("switch_gap", 128'(cyc - last_wr), 128'd1);
                if (exp_sw.size() == 0) begin
                    fail_now("unexpected_switch");
                end else begin
                    le = exp_sw.pop_front();
                    check("loop_end", {127'd0, loop_end}, {127'd0, le});
                    if (loop_end) check("busy_at_loop_end", {127'd0, busy}, 128'd1);
                end
            end else if (loop_end) begin
                fail_now("loop_end_without_switch");
            end
        end
    end

    // Consumer model: releases each filled buffer some random cycles after its switch pulse.
    always @(posedge clk) begin
        #1;
        if (sync_req) begin
            rel_issued = sw_seen;
            rel_auto   = 1'b0;
        end else if (auto_rel && (sw_seen > rel_issued) && ($urandom_range(0, 2) == 0)) begin
            rel_auto = 1'b1;
            rel_issued++;
        end else begin
            rel_auto = 1'b0;
        end
    end

    task automatic start_loop(input int len_cfg, input int num_cfg, input bit seq);
        int eff_len;
        int eff_num;
        logic [127:0] w;
        logic [31:0]  b;
        eff_len = (len_cfg == 0) ? 1024 : len_cfg;
        eff_num = (num_cfg == 0) ? 256 : num_cfg;
        for (int i = 0; i < eff_len * eff_num; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                b = seq ? 32'(4 * i + k + 1) : $urandom;
                beats.push_back(b);
                w[32*k +: 32] = b;
            end
            exp_wr.push_back('{10'(i % eff_len), w});
            if ((i % eff_len) == eff_len - 1) exp_sw.push_back((i / eff_len) == eff_num - 1);
        end
        cfg_tile_len = 10'(len_cfg);
        cfg_tile_num = 8'(num_cfg);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", {127'd0, busy}, 128'd1);
    endtask

    // mode 0: continuous, 1: every other cycle, 2: random
    task automatic feed(input int n, input int mode, input int budget, output bit ok);
        int got = 0;
        int t   = 0;
        bit acc;
        ok = 1'b1;
        while (got < n) begin
            if (t >= budget) begin
                ok = 1'b0;
                break;
            end
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (t % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = (beats.size() > 0) ? beats[0] : 32'hdead_beef;
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                void'(beats.pop_front());
                got++;
            end
            t++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now("wait_idle_timeout");
        @(posedge clk); #1;
        check("exp_wr_empty", 128'(exp_wr.size()), 128'd0);
        check("exp_sw_empty", 128'(exp_sw.size()), 128'd0);
    endtask

    // Release every buffer manually; surplus pulses exercise the saturation at zero.
    task automatic drain_manual();
        repeat (3) begin
            rel_man = 1'b1;
            @(posedge clk); #1;
            rel_man = 1'b0;
            @(posedge clk); #1;
        end
        sync_req = 1'b1;
        @(posedge clk); #1;
        sync_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},    {127'd0, ifm_wr_en},     128'd0);
        check({tag, "_wr_addr"},  {118'd0, ifm_wr_addr},   128'd0);
        check({tag, "_ifm_in"},   ifm_in,                  128'd0);
        check({tag, "_switch"},   {127'd0, buf_in_switch}, 128'd0);
        check({tag, "_loop_end"}, {127'd0, loop_end},      128'd0);
        check({tag, "_busy"},     {127'd0, busy},          128'd0);
        check({tag, "_in_ready"}, {127'd0, in_ready},      128'd0);
    endtask

    initial begin
        bit ok;
        bit stuck;
        int len;
        int num;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_tile_len = '0;
        cfg_tile_num = '0;
        in_data  = '0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-word single tile with sequential beats 1..8
        start_loop(2, 1, 1'b1);
        feed(8, 0, 100, ok);
        check("t1_feed", {127'd0, ok}, 128'd1);
        wait_idle(50);
        drain_manual();

        // Three tiles without releases: third tile must wait for one release
        start_loop(1, 3, 1'b0);
        feed(8, 0, 100, ok);
        check("t2_feed_two_tiles", {127'd0, ok}, 128'd1);
        in_valid = 1'b1;
        in_data  = beats[0];
        stuck    = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (in_ready) stuck = 1'b1;
        end
        check("t2_wait_buf_hold", {127'd0, stuck}, 128'd0);
        in_valid = 1'b0;
        rel_man  = 1'b1;
        @(posedge clk); #1;
        rel_man  = 1'b0;
        feed(4, 0, 100, ok);
        check("t2_feed_third_tile", {127'd0, ok}, 128'd1);
        wait_idle(50);
        drain_manual();

        // Release coinciding with a fill at full_cnt=1: loading must continue
        start_loop(1, 3, 1'b0);
        feed(4, 0, 100, ok);
        feed(4, 0, 100, ok);
        rel_man = 1'b1;              // this cycle the DUT is in SWITCH
        @(posedge clk); #1;
        rel_man = 1'b0;
        feed(4, 0, 60, ok);
        check("t3_same_cycle_continue", {127'd0, ok}, 128'd1);
        wait_idle(50);
        drain_manual();

        // Alternating valid, auto releases
        auto_rel = 1'b1;
        start_loop(3, 2, 1'b0);
        feed(24, 1, 400, ok);
        check("t4_feed_alt", {127'd0, ok}, 128'd1);
        wait_idle(100);

        // tile_len=0 encodes 1024 words
        start_loop(0, 1, 1'b0);
        feed(4096, 0, 5000, ok);
        check("t5_feed_1024", {127'd0, ok}, 128'd1);
        wait_idle(100);

        // Random configurations with random valid
        for (int r = 0; r < 3; r++) begin
            len = $urandom_range(1, 5);
            num = $urandom_range(1, 4);
            start_loop(len, num, 1'b0);
            feed(4 * len * num, 2, 4 * len * num * 10 + 200, ok);
            check("t6_feed_random", {127'd0, ok}, 128'd1);
            wait_idle(100);
        end
        for (int i = 0; i < 200 && sw_seen != rel_issued; i++) @(posedge clk);
        check("t6_released_all", 128'(sw_seen - rel_issued), 128'd0);
        auto_rel = 1'b0;
        @(posedge clk); #1;

        // Reset after two beats of a word
        start_loop(2, 1, 1'b0);
        feed(2, 0, 50, ok);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_wr.delete();
        exp_sw.delete();
        beats.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        sync_req = 1'b1;
        @(posedge clk); #1;
        sync_req = 1'b0;
        start_loop(1, 1, 1'b0);
        feed(4, 0, 50, ok);
        check("t7_feed_after_reset", {127'd0, ok}, 128'd1);
        wait_idle(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
